// File: rtl/music_player_pkg.sv
// music_player_pkg: shared widths, FSM states, note step and amplitude tables
// for the 4-song square-wave music player.
package music_player_pkg;
    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int SONG_W  = 2;
    localparam int IDX_W   = 5;
    localparam int PHASE_W = 20;
    localparam int ROM_AW  = SONG_W + IDX_W;
    localparam int ROM_DW  = NOTE_W + DUR_W;

    typedef enum logic [1:0] {STOP, PLAY, PAUSE} state_e;

    // Octave-0 phase steps at 48 kHz for a 20-bit accumulator, A1 = 55 Hz upward.
    localparam logic [11:0] BASE_STEP [12] = '{
        12'd1202, 12'd1273, 12'd1349, 12'd1429, 12'd1514, 12'd1604,
        12'd1699, 12'd1800, 12'd1907, 12'd2021, 12'd2141, 12'd2268
    };

    localparam logic [15:0] AMP [4] = '{16'h1000, 16'h2000, 16'h4000, 16'h7FFF};

    function automatic logic [PHASE_W-1:0] note_step(input logic [NOTE_W-1:0] nt);
        logic [NOTE_W-1:0] n;
        n = nt - 1'b1;
        return PHASE_W'(BASE_STEP[4'(n % 6'd12)]) << (n / 6'd12);
    endfunction
endpackage

// File: rtl/song_rom.sv
// song_rom: 128 x 12 song table addressed by {song, note index}; each entry is
// {note, dur}, dur = 0 ends the song and note = 0 is a rest. Registered read.
module song_rom
    import music_player_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [ROM_DW-1:0] data_o
);
    logic [ROM_DW-1:0] rom_d;

    always_comb begin
        case (addr_i)
            7'h00:   rom_d = {6'd1,  6'd5};
            7'h01:   rom_d = {6'd13, 6'd2};
            7'h02:   rom_d = {6'd0,  6'd1};
            7'h03:   rom_d = {6'd25, 6'd1};
            7'h20:   rom_d = {6'd5,  6'd1};
            7'h21:   rom_d = {6'd17, 6'd1};
            7'h22:   rom_d = {6'd3,  6'd2};
            7'h40:   rom_d = {6'd8,  6'd2};
            7'h41:   rom_d = {6'd20, 6'd1};
            7'h60:   rom_d = {6'd40, 6'd1};
            7'h61:   rom_d = {6'd63, 6'd1};
            default: rom_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        data_o <= rom_d;
    end
endmodule

// File: rtl/music_player.sv
// music_player: 4-song player; beat timer, play/pause/next sequencer and a
// phase-accumulator square-wave synth producing one PCM sample per codec frame.
module music_player
    import music_player_pkg::*;
#(
    parameter int BEAT_COUNT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic [1:0]        weight,
    input  logic              new_frame,
    input  logic              ff_switch0,
    input  logic              r_switch1,
    output logic [15:0]       sample_out,
    output logic [SONG_W-1:0] current_song,
    output logic              play
);
    localparam int BW = $clog2(BEAT_COUNT + 2);

    state_e             state_q, state_d;
    logic [SONG_W-1:0]  song_q, song_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [DUR_W-1:0]   nbeats_q, nbeats_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [15:0]        sample_q, sample_d;
    logic [ROM_DW-1:0]  rom_data;
    logic [NOTE_W-1:0]  note;
    logic [DUR_W-1:0]   dur;
    logic [BW-1:0]      beat_sum;
    logic               beat, tick, done, step_en, clr, adv, rew_stop;

    song_rom u_rom (
        .clk    (clk),
        .addr_i ({song_q, idx_q}),
        .data_o (rom_data)
    );

    assign {note, dur} = rom_data;

    // ROM data for the current index has settled long before the next frame arrives.
    assign tick    = new_frame && (state_q == PLAY);
    assign done    = tick && (dur == '0);
    assign step_en = tick && !done;
    assign clr     = done || next_button;

    always_comb begin
        beat_sum = beat_q + (ff_switch0 ? BW'(2) : BW'(1));
        beat     = beat_sum >= BW'(BEAT_COUNT);
        beat_d   = clr ? '0 : !step_en ? beat_q : beat ? beat_sum - BW'(BEAT_COUNT) : beat_sum;
    end

    assign adv      = step_en && beat && (nbeats_q + 1'b1 == dur);
    assign rew_stop = adv && r_switch1 && (idx_q == '0);

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        idx_d    = idx_q;
        nbeats_d = nbeats_q;
        if (play_button)
            state_d = (state_q == PLAY) ? PAUSE : PLAY;
        if (step_en) begin
            nbeats_d = adv ? '0 : nbeats_q + DUR_W'(beat);
            if (adv)
                idx_d = !r_switch1 ? idx_q + 1'b1 : (idx_q == '0) ? idx_q : idx_q - 1'b1;
        end
        if (rew_stop)
            state_d = STOP;
        if (clr) begin
            state_d  = STOP;
            song_d   = song_q + 1'b1;
            idx_d    = '0;
            nbeats_d = '0;
        end
    end

    // Each frame refreshes the sample; rests and non-playing frames output silence.
    always_comb begin
        phase_d  = phase_q;
        sample_d = sample_q;
        if (new_frame)
            sample_d = '0;
        if (step_en && note != '0) begin
            phase_d  = phase_q + note_step(note);
            sample_d = phase_q[PHASE_W-1] ? -AMP[weight] : AMP[weight];
        end
        if (clr) begin
            phase_d  = '0;
            sample_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STOP;
            song_q   <= '0;
            idx_q    <= '0;
            beat_q   <= '0;
            nbeats_q <= '0;
            phase_q  <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            song_q   <= song_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            nbeats_q <= nbeats_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
        end
    end

    assign sample_out   = sample_q;
    assign current_song = song_q;
    assign play         = (state_q == PLAY);
endmodule

// File: tb/tb_music_player.sv
// tb_music_player: randomized bench; a song-level model predicts every frame's
// {sample_out, play, current_song} into a queue that a frame monitor consumes.
module tb_music_player;
    localparam int BC   = 100;
    localparam int FULL = 1 << 20;
    localparam int HALF = 1 << 19;
    localparam int AMPS [4] = '{4096, 8192, 16384, 32767};
    localparam int S_NOTE [4][5] = '{'{1, 13, 0, 25, 0}, '{5, 17, 3, 0, 0}, '{8, 20, 0, 0, 0}, '{40, 63, 0, 0, 0}};
    localparam int S_DUR  [4][5] = '{'{5, 2, 1, 1, 0},   '{1, 1, 2, 0, 0},  '{2, 1, 0, 0, 0},  '{1, 1, 0, 0, 0}};

    logic        clk = 1'b0;
    logic        reset, play_button, next_button, new_frame, ff_switch0, r_switch1;
    logic [1:0]  weight;
    logic [15:0] sample_out;
    logic [1:0]  current_song;
    logic        play;

    int          tests = 0;
    int          fails = 0;
    logic [18:0] exp_q [$];
    bit          m_play;
    int          m_song, m_idx, m_t, m_nsb, m_phase;

    music_player #(.BEAT_COUNT(BC)) dut (
        .clk          (clk),
        .reset        (reset),
        .play_button  (play_button),
        .next_button  (next_button),
        .weight       (weight),
        .new_frame    (new_frame),
        .ff_switch0   (ff_switch0),
        .r_switch1    (r_switch1),
        .sample_out   (sample_out),
        .current_song (current_song),
        .play         (play)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Equal-tempered frequency from A1 = 55 Hz, converted to a 20-bit phase step at 48 kHz.
    function automatic int step_of(input int nt);
        int  k;
        real f;
        k = (nt - 1) % 12;
        f = 55.0 * $pow(2.0, k / 12.0);
        return $rtoi(f * 1048576.0 / 48000.0 + 0.5) << ((nt - 1) / 12);
    endfunction

    function automatic int rom_note(input int s, input int i);
        return (i < 5) ? S_NOTE[s][i] : 0;
    endfunction

    function automatic int rom_dur(input int s, input int i);
        return (i < 5) ? S_DUR[s][i] : 0;
    endfunction

    task automatic model_clear;
        m_idx   = 0;
        m_t     = 0;
        m_nsb   = 0;
        m_phase = 0;
    endtask

    task automatic do_frame(input logic ff, input logic r, input logic [1:0] w);
        int          nt, d;
        logic [15:0] s;
        nt = rom_note(m_song, m_idx);
        d  = rom_dur(m_song, m_idx);
        s  = '0;
        if (m_play) begin
            if (d == 0) begin
                m_play = 1'b0;
                m_song = (m_song + 1) % 4;
                model_clear();
            end else begin
                if (nt != 0) begin
                    s       = (m_phase >= HALF) ? 16'(-AMPS[w]) : 16'(AMPS[w]);
                    m_phase = (m_phase + step_of(nt)) % FULL;
                end
                m_t += ff ? 2 : 1;
                if (m_t / BC - m_nsb >= d) begin
                    m_nsb = m_t / BC;
                    if (!r)
                        m_idx = (m_idx + 1) % 32;
                    else if (m_idx > 0)
                        m_idx--;
                    else
                        m_play = 1'b0;
                end
            end
        end
        exp_q.push_back({s, m_play, 2'(m_song)});
        @(negedge clk);
        ff_switch0 = ff;
        r_switch1  = r;
        weight     = w;
        new_frame  = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_frame(input logic r);
        do_frame(1'($urandom_range(0, 1)), r, 2'($urandom_range(0, 3)));
    endtask

    task automatic press_play;
        @(negedge clk);
        play_button = 1'b1;
        @(negedge clk);
        play_button = 1'b0;
        m_play = !m_play;
        check("play after play_button", int'(play), int'(m_play));
    endtask

    task automatic press_next;
        @(negedge clk);
        next_button = 1'b1;
        @(negedge clk);
        next_button = 1'b0;
        m_play = 1'b0;
        m_song = (m_song + 1) % 4;
        model_clear();
        check("play after next_button", int'(play), 0);
        check("song after next_button", int'(current_song), m_song);
        check("sample after next_button", int'(sample_out), 0);
    endtask

    task automatic run_to_stop(input int max_frames, input logic r);
        int n;
        n = 0;
        while (m_play && n < max_frames) begin
            rand_frame(r);
            n++;
        end
        check("play low at stop", int'(play), 0);
    endtask

    initial begin : monitor
        logic [18:0] e;
        int          nf;
        nf = 0;
        forever begin
            @(posedge clk);
            if (new_frame) begin
                #1;
                nf++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL frame %0d: DUT frame with no expected entry", nf);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("frame %0d sample_out", nf), int'(sample_out), int'(e[18:3]));
                    check($sformatf("frame %0d play", nf), int'(play), int'(e[2]));
                    check($sformatf("frame %0d current_song", nf), int'(current_song), int'(e[1:0]));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        play_button = 1'b0;
        next_button = 1'b0;
        new_frame   = 1'b0;
        ff_switch0  = 1'b0;
        r_switch1   = 1'b0;
        weight      = 2'd0;
        m_play      = 1'b0;
        m_song      = 0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("reset play", int'(play), 0);
        check("reset current_song", int'(current_song), 0);
        check("reset sample_out", int'(sample_out), 0);
        repeat (4) rand_frame(1'b0);
        // First note at full weight: long enough for the square wave to flip sign.
        press_play();
        repeat (520) do_frame(1'b0, 1'b0, 2'd3);
        press_play();
        repeat (500) rand_frame(1'b0);
        press_play();
        run_to_stop(2000, 1'b0);
        check("song after song 0 ends", int'(current_song), 1);
        for (int s = 0; s < 3; s++) begin
            press_play();
            run_to_stop(1000, 1'b0);
        end
        check("song wraps after song 3", int'(current_song), 0);
        press_play();
        repeat (150) rand_frame(1'b0);
        press_next();
        press_next();
        press_play();
        repeat (50) rand_frame(1'b0);
        press_next();
        press_next();
        // Rewind at index 0 stops on the next advance and stays on the same song.
        press_play();
        run_to_stop(700, 1'b1);
        check("song after rewind stop", int'(current_song), m_song);
        press_play();
        repeat (300) rand_frame(1'($urandom_range(0, 3) == 0));
        if (!m_play)
            press_play();
        repeat (30) rand_frame(1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("mid-song reset play", int'(play), 0);
        check("mid-song reset current_song", int'(current_song), 0);
        check("mid-song reset sample_out", int'(sample_out), 0);
        m_play = 1'b0;
        m_song = 0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) rand_frame(1'b0);
        press_play();
        repeat (20) rand_frame(1'b0);
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
